// File: rtl/lc3_fetch_unit_if.sv
// LC3 fetch unit bus bundle.
// Memory read port plus the decode-facing handshake.
interface lc3_fetch_unit_if;
  logic        stall;
  logic        br_taken;
  logic [15:0] taddr;
  logic [2:0]  psr_wb;
  logic [15:0] instr_mem_dout;
  logic [15:0] pc;
  logic        instrmem_rd;
  logic [15:0] npc_in;
  logic [15:0] Instr_dout;
  logic [2:0]  psr;
  logic        enable_decode;

  modport master (
    input  stall,
    input  br_taken,
    input  taddr,
    input  psr_wb,
    input  instr_mem_dout,
    output pc,
    output instrmem_rd,
    output npc_in,
    output Instr_dout,
    output psr,
    output enable_decode
  );

  modport slave (
    output stall,
    output br_taken,
    output taddr,
    output psr_wb,
    output instr_mem_dout,
    input  pc,
    input  instrmem_rd,
    input  npc_in,
    input  Instr_dout,
    input  psr,
    input  enable_decode
  );
endinterface

// File: rtl/lc3_fetch_unit.sv
// LC3 instruction fetch stage.
// Credit-based reads, in-flight tags, buffered hand-off to decode.
module lc3_fetch_unit #(
  parameter logic [15:0] START_PC    = 16'h3000,
  parameter int          MEM_LATENCY = 1,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_fetch,
  lc3_fetch_unit_if.master  bus
);

  localparam int L  = MEM_LATENCY;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [15:0]   r_pc;
  logic [L-1:0]  r_tag_v;
  logic [15:0]   r_tag_npc [L];
  logic [15:0]   r_buf_ins [FIFO_DEPTH];
  logic [15:0]   r_buf_npc [FIFO_DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [15:0]   r_npc;
  logic [15:0]   r_ins;
  logic [2:0]    r_psr;
  logic          r_ed;

  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [4:0]    w_inflight;
  logic [4:0]    w_used;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit accounting: buffered + in-flight, less what leaves now.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < L; i++)
      w_inflight = w_inflight + {4'b0, r_tag_v[i]};
    w_pop  = (r_count != '0) & enable_fetch
           & ~bus.stall & ~bus.br_taken;
    w_push = r_tag_v[L-1];
    w_used = {{(5-CW){1'b0}}, r_count} + w_inflight
           - {4'b0, w_pop};
    w_issue = reset & enable_fetch & ~bus.br_taken
            & (w_used < 5'(FIFO_DEPTH));
  end

  // Program counter: redirect wins, else advance on issue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_pc <= START_PC;
    else if (bus.br_taken)
      r_pc <= bus.taddr;
    else if (w_issue)
      r_pc <= r_pc + 16'd1;
  end

  // In-flight tag pipe, one stage per cycle of memory latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tag_v <= '0;
      for (int i = 0; i < L; i++)
        r_tag_npc[i] <= '0;
    end else if (bus.br_taken) begin
      r_tag_v <= '0;
    end else begin
      r_tag_v[0]   <= w_issue;
      r_tag_npc[0] <= r_pc + 16'd1;
      for (int i = 1; i < L; i++) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_npc[i] <= r_tag_npc[i-1];
      end
    end
  end

  // Instruction buffer: circular queue, flushed on redirect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_buf_ins[i] <= '0;
        r_buf_npc[i] <= '0;
      end
    end else if (bus.br_taken) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_buf_ins[r_tail] <= bus.instr_mem_dout;
        r_buf_npc[r_tail] <= r_tag_npc[L-1];
        r_tail            <= f_inc(r_tail);
      end
      if (w_pop)
        r_head <= f_inc(r_head);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Decode-facing registers: load on pop, hold otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ed  <= 1'b0;
      r_ins <= '0;
      r_npc <= '0;
      r_psr <= '0;
    end else if (w_pop) begin
      r_ed  <= 1'b1;
      r_ins <= r_buf_ins[r_head];
      r_npc <= r_buf_npc[r_head];
      r_psr <= bus.psr_wb;
    end else begin
      r_ed  <= 1'b0;
    end
  end

  assign bus.pc            = r_pc;
  assign bus.instrmem_rd   = w_issue;
  assign bus.npc_in        = r_npc;
  assign bus.Instr_dout    = r_ins;
  assign bus.psr           = r_psr;
  assign bus.enable_decode = r_ed;

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Directed bench for lc3_fetch_unit.
// Two instances: latency 1/depth 4 and latency 3/depth 5.
module tb_lc3_fetch_unit;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic ef_a;
  logic ef_b;
  int   n_chk;
  int   n_pass;
  int   ovf;
  int   nb;
  logic [15:0] exp_npc;
  logic [15:0] exp_b;
  logic [15:0] ma_q [1];
  logic [15:0] mb_q [3];

  lc3_fetch_unit_if ifa ();
  lc3_fetch_unit_if ifb ();

  lc3_fetch_unit #(
    .START_PC    (16'h3000),
    .MEM_LATENCY (1),
    .FIFO_DEPTH  (4)
  ) dut_a (
    .clock        (clk),
    .reset        (rst_a),
    .enable_fetch (ef_a),
    .bus          (ifa)
  );

  lc3_fetch_unit #(
    .START_PC    (16'h3000),
    .MEM_LATENCY (3),
    .FIFO_DEPTH  (5)
  ) dut_b (
    .clock        (clk),
    .reset        (rst_b),
    .enable_fetch (ef_b),
    .bus          (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: word at addr is addr-16'h2000, so 3000+i holds 1000+i.
  always @(posedge clk) begin
    ma_q[0] <= ifa.pc;
    mb_q[0] <= ifb.pc;
    mb_q[1] <= mb_q[0];
    mb_q[2] <= mb_q[1];
  end
  assign ifa.instr_mem_dout = ma_q[0] - 16'h2000;
  assign ifb.instr_mem_dout = mb_q[2] - 16'h2000;

  // Flag any write into a full buffer.
  always @(posedge clk) begin
    if (dut_a.w_push && !dut_a.w_pop && int'(dut_a.r_count) == 4)
      ovf <= ovf + 1;
    if (dut_b.w_push && !dut_b.w_pop && int'(dut_b.r_count) == 5)
      ovf <= ovf + 1;
  end

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("ed", {15'b0, ifa.enable_decode}, 16'd1);
      chk("npc", ifa.npc_in, exp_npc);
      chk("ins", ifa.Instr_dout, exp_npc - 16'h1 - 16'h2000);
      exp_npc = exp_npc + 16'd1;
    end
  endtask

  task automatic no_ed(input string tag);
    @(negedge clk);
    chk(tag, {15'b0, ifa.enable_decode}, 16'd0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; ovf = 0; nb = 0;
    rst_a = 1'b0; rst_b = 1'b0;
    ef_a = 1'b1; ef_b = 1'b0;
    ifa.stall = 1'b0; ifa.br_taken = 1'b0;
    ifa.taddr = '0; ifa.psr_wb = 3'b010;
    ifb.stall = 1'b0; ifb.br_taken = 1'b0;
    ifb.taddr = '0; ifb.psr_wb = 3'b001;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_rd", {15'b0, ifa.instrmem_rd}, 16'd0);
    chk("rst_pc", ifa.pc, 16'h3000);
    chk("rst_ed", {15'b0, ifa.enable_decode}, 16'd0);
    chk("rst_ins", ifa.Instr_dout, 16'h0000);
    chk("rst_npc", ifa.npc_in, 16'h0000);
    chk("rst_psr", {13'b0, ifa.psr}, 16'd0);

    // first fetch latency then streaming
    rst_a = 1'b1;
    #1 chk("rd_c0", {15'b0, ifa.instrmem_rd}, 16'd1);
    no_ed("ed_c1");
    no_ed("ed_c2");
    exp_npc = 16'h3001;
    stream(4);
    chk("psr", {13'b0, ifa.psr}, 16'h0002);

    // decode stall for six cycles
    ifa.stall = 1'b1;
    for (int i = 0; i < 6; i++) no_ed("ed_stall");
    chk("rd_stall", {15'b0, ifa.instrmem_rd}, 16'd0);
    ifa.stall = 1'b0;
    stream(5);

    // redirect to 4000
    ifa.br_taken = 1'b1;
    ifa.taddr = 16'h4000;
    no_ed("ed_br");
    chk("pc_br", ifa.pc, 16'h4000);
    ifa.br_taken = 1'b0;
    no_ed("ed_br1");
    no_ed("ed_br2");
    exp_npc = 16'h4001;
    stream(3);

    // pc wrap around 16'hFFFF
    ifa.br_taken = 1'b1;
    ifa.taddr = 16'hFFFE;
    @(negedge clk);
    chk("pc_fffe", ifa.pc, 16'hFFFE);
    ifa.br_taken = 1'b0;
    @(negedge clk);
    chk("pc_ffff", ifa.pc, 16'hFFFF);
    @(negedge clk);
    chk("pc_wrap", ifa.pc, 16'h0000);
    exp_npc = 16'hFFFF;
    stream(3);

    // async reset mid-cycle while streaming
    #2 rst_a = 1'b0;
    #1;
    chk("ar_ed", {15'b0, ifa.enable_decode}, 16'd0);
    chk("ar_pc", ifa.pc, 16'h3000);
    chk("ar_ins", ifa.Instr_dout, 16'h0000);
    chk("ar_npc", ifa.npc_in, 16'h0000);
    chk("ar_psr", {13'b0, ifa.psr}, 16'd0);
    chk("ar_rd", {15'b0, ifa.instrmem_rd}, 16'd0);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    no_ed("ar_ed1");
    no_ed("ar_ed2");
    exp_npc = 16'h3001;
    stream(3);

    // latency 3, depth 5, enable toggled every 4 cycles
    rst_b = 1'b1;
    ef_b = 1'b1;
    exp_b = 16'h3001;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (!ef_b)
        chk("b_hold", {15'b0, ifb.enable_decode}, 16'd0);
      if (ifb.enable_decode) begin
        chk("b_npc", ifb.npc_in, exp_b);
        chk("b_ins", ifb.Instr_dout, exp_b - 16'h1 - 16'h2000);
        exp_b = exp_b + 16'd1;
        nb++;
      end
      if (c % 4 == 3) ef_b = ~ef_b;
    end
    chk("b_count", {15'b0, nb >= 25}, 16'd1);
    chk("ovf", ovf[15:0], 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lc3_fetch_unit.md
Name: lc3_fetch_unit

Overview:
- LC3 instruction-fetch stage, directly upstream of decode.
- Issues reads to instruction memory and tracks in-flight reads over a fixed memory latency.
- Buffers returned instructions and presents each one to decode as Instr_dout/npc_in/psr, with a one-cycle enable_decode pulse per instruction.
- Handles decode backpressure (stall) and branch redirect/flush (br_taken/taddr).

Parameters:
- START_PC, 16'h3000: PC value loaded at reset.
- MEM_LATENCY, 1: cycles from instrmem_rd to valid instr_mem_dout. Legal range 1..4.
- FIFO_DEPTH, 4: instruction buffer entries. Legal range 2..8. Must be >= MEM_LATENCY+2 for 1 instr/cycle throughput.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable_fetch  in  1  global run enable from controller.
- stall  in  1  decode cannot accept this cycle.
- br_taken  in  1  redirect request.
- taddr  in  16  redirect target PC.
- psr_wb  in  3  current NZP from writeback.
- instr_mem_dout  in  16  instruction memory read data.
- pc  out  16  instruction memory address (register).
- instrmem_rd  out  1  memory read strobe (combinational).
- npc_in  out  16  PC+1 of presented instruction (register).
- Instr_dout  out  16  presented instruction (register).
- psr  out  3  psr_wb sampled at presentation (register).
- enable_decode  out  1  one-cycle valid per instruction (register).

Behaviour:
- Reset (async assert, sync release):
  - pc=START_PC; instrmem_rd=0; npc_in=0; Instr_dout=0; psr=0; enable_decode=0.
  - Buffer empty; all in-flight slots invalid.
- pop = buffer nonempty & enable_fetch & !stall & !br_taken.
- issue = enable_fetch & !br_taken & (count + inflight - pop) < FIFO_DEPTH.
- instrmem_rd = issue. Combinational from stall/br_taken is permitted.
- On issue, at the clock edge:
  - pc <= pc+1, mod 2^16 (16'hFFFF wraps to 16'h0000).
  - Push tag {valid=1, npc=pc+1} into a MEM_LATENCY-deep in-flight shift register.
- Data for a read issued in cycle n is valid during cycle n+MEM_LATENCY. It is written to the buffer tail at the end of that cycle only if its tag is valid.
- Credit rule guarantees no push to a full buffer. A push to a full buffer is a design error; the bench asserts on it.
- Push and pop in the same cycle are legal; count is unchanged.
- On a pop edge:
  - enable_decode <= 1; Instr_dout <= head.instr; npc_in <= head.npc; psr <= psr_wb.
  - Head advances.
- Otherwise enable_decode <= 0, and Instr_dout/npc_in/psr hold their values.
- Minimum latency, rd to enable_decode high: MEM_LATENCY+2 cycles (buffer write, pop decision, registered output).
- Sustained throughput: 1 instruction per cycle when stall=0 and FIFO_DEPTH >= MEM_LATENCY+2.
- br_taken=1 (regardless of enable_fetch):
  - pc <= taddr.
  - Buffer flushed (count <= 0).
  - All in-flight tags cleared; their returning data is discarded.
  - No issue and no pop this cycle, so enable_decode is 0 next cycle.
  - Fetch resumes from taddr the following cycle.
- br_taken has priority over stall and over a push arriving in the same cycle (that push is dropped).
- enable_fetch=0: no issue, no pop. In-flight reads still return and are buffered. pc holds.
- stall=1: no pop. Issue continues until credits are exhausted, then instrmem_rd=0. No instruction is lost or duplicated.
- Async reset mid-operation: all state returns to reset values immediately. Data returning after release is ignored (tags invalid).

Test Plan:
- Reset, then enable_fetch=1, MEM_LATENCY=1, memory[3000+i]=16'h1000+i:
  - instrmem_rd high from cycle 0.
  - First enable_decode in cycle 3 with Instr_dout=16'h1000, npc_in=16'h3001.
  - Then one instruction per cycle, contiguous.
- stall=1 for 6 cycles mid-stream:
  - enable_decode=0 during stall.
  - instrmem_rd drops after count+inflight reaches 4.
  - After release, the sequence continues with no gap in npc_in values and no duplicates.
- br_taken=1 with taddr=16'h4000 while 3 reads are in flight or buffered:
  - Those instructions are never presented.
  - pc=16'h4000 next cycle.
  - Next presented npc_in=16'h4001.
- pc=16'hFFFE, free-running: presented npc_in sequence FFFF, 0000, 0001; pc wraps to 0000.
- reset asserted asynchronously mid-clock-cycle during streaming:
  - Outputs zero immediately; pc=3000.
  - After release, first presented npc_in=16'h3001.
- MEM_LATENCY=3, FIFO_DEPTH=5, toggle enable_fetch 0/1 every 4 cycles:
  - Every fetched address is presented exactly once, in order.
  - The buffer never overflows (assertion).
